// File: rtl/pc_unit_pkg.sv
// Shared types and constants for the next-PC stage.
//   pc_state_e : RUN/TRAP sequencing of exception entry
//   CAUSE_*    : cause codes written into the CAUSE register
//   EPC_SEL    : pc_src value that selects EPC (ERET) for the default 4-source build
package pc_unit_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } pc_state_e;

    localparam int unsigned CAUSE_W = 5;

    localparam logic [CAUSE_W-1:0] CAUSE_INT  = 5'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_ADEL = 5'd4;
    localparam logic [CAUSE_W-1:0] CAUSE_RI   = 5'd10;
    localparam logic [CAUSE_W-1:0] CAUSE_OV   = 5'd12;

    localparam int unsigned DEF_NUM_SRC = 4;
    localparam int unsigned EPC_SEL     = DEF_NUM_SRC;

    // The EPC slot always sits directly after the last external source.
    function automatic int unsigned epc_sel_for(input int unsigned num_src);
        return num_src;
    endfunction

endpackage

// File: rtl/pc_src_mux.sv
// N+1-way PC source select: external slots 0..NUM_SRC-1 from a packed bus,
// slot NUM_SRC is EPC (ERET). Any larger index is flagged as invalid and
// yields an all-zero target so it can never look misaligned.
//   i_sel     : source index
//   i_src_bus : packed sources, slot k = i_src_bus[k*WIDTH +: WIDTH]
//   i_epc     : exception PC
//   o_target  : selected target (combinational)
//   o_sel_err : index beyond EPC slot (combinational, not qualified by write)
module pc_src_mux
    import pc_unit_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SEL_W   = 3
) (
    input  logic [SEL_W-1:0]         i_sel,
    input  logic [NUM_SRC*WIDTH-1:0] i_src_bus,
    input  logic [WIDTH-1:0]         i_epc,
    output logic [WIDTH-1:0]         o_target,
    output logic                     o_sel_err
);

    localparam logic [SEL_W-1:0] SEL_EPC = SEL_W'(epc_sel_for(NUM_SRC));

    // Source select
    always_comb begin
        o_target = '0;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            if (i_sel == SEL_W'(k)) begin
                o_target = i_src_bus[k*WIDTH +: WIDTH];
            end
        end
        if (i_sel == SEL_EPC) begin
            o_target = i_epc;
        end
    end

    assign o_sel_err = (i_sel > SEL_EPC);

endmodule

// File: rtl/pc_next_unit.sv
// Next-PC stage of the multicycle datapath: PC, EPC and CAUSE registers
// plus the two-cycle exception entry sequence (RUN -> TRAP -> RUN).
//   clk, reset          : clock, async active-high reset
//   pc_write            : unconditional PC load
//   pc_write_cond       : branch PC load, qualified by alu_zero/branch_ne
//   branch_ne, alu_zero : branch sense and ALU zero flag
//   pc_src              : source index (NUM_SRC selects EPC)
//   src_bus             : packed external PC sources
//   exc_req, exc_code   : exception request and its cause code
//   pc, epc, cause      : architectural registers
//   exc_taken           : pulse in the cycle PC holds EXC_VECTOR
//   sel_err             : combinational, write enabled with invalid pc_src
module pc_next_unit
    import pc_unit_pkg::*;
#(
    parameter int unsigned       WIDTH        = 32,
    parameter int unsigned       NUM_SRC      = 4,
    parameter int unsigned       SEL_W        = 3,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0]  EXC_VECTOR   = 32'h0000_00FC,
    parameter int unsigned       PC_INC       = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pc_write,
    input  logic                     pc_write_cond,
    input  logic                     branch_ne,
    input  logic                     alu_zero,
    input  logic [SEL_W-1:0]         pc_src,
    input  logic [NUM_SRC*WIDTH-1:0] src_bus,
    input  logic                     exc_req,
    input  logic [CAUSE_W-1:0]       exc_code,
    output logic [WIDTH-1:0]         pc,
    output logic [WIDTH-1:0]         epc,
    output logic [CAUSE_W-1:0]       cause,
    output logic                     exc_taken,
    output logic                     sel_err
);

    pc_state_e          r_state;
    logic [WIDTH-1:0]   r_pc;
    logic [WIDTH-1:0]   r_epc;
    logic [CAUSE_W-1:0] r_cause;
    logic               r_exc_taken;

    logic [WIDTH-1:0]   w_target;
    logic               w_sel_bad;
    logic               w_load_en;
    logic               w_misaligned;
    logic [WIDTH-1:0]   w_epc_next;

    pc_src_mux #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_src_mux (
        .i_sel     (pc_src),
        .i_src_bus (src_bus),
        .i_epc     (r_epc),
        .o_target  (w_target),
        .o_sel_err (w_sel_bad)
    );

    // beq takes on zero, bne on non-zero
    assign w_load_en    = pc_write | (pc_write_cond & (alu_zero ^ branch_ne));
    assign sel_err      = w_load_en & w_sel_bad;
    // Invalid selects produce no target, so they never count as misaligned
    assign w_misaligned = w_load_en & ~w_sel_bad & (w_target[1:0] != 2'b00);
    // PC was already advanced at fetch; wraps modulo 2**WIDTH
    assign w_epc_next   = r_pc - WIDTH'(PC_INC);

    // PC/EPC/CAUSE registers and exception sequencing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_pc        <= RESET_VECTOR;
            r_epc       <= '0;
            r_cause     <= CAUSE_INT;
            r_exc_taken <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_exc_taken <= 1'b0;
                    if (exc_req) begin
                        r_epc   <= w_epc_next;
                        r_cause <= exc_code;
                        r_state <= ST_TRAP;
                    end else if (w_misaligned) begin
                        r_epc   <= w_epc_next;
                        r_cause <= CAUSE_ADEL;
                        r_state <= ST_TRAP;
                    end else if (w_load_en && !w_sel_bad) begin
                        r_pc <= w_target;
                    end
                end
                ST_TRAP: begin
                    // All load/exception inputs are ignored here
                    r_pc        <= EXC_VECTOR;
                    r_exc_taken <= 1'b1;
                    r_state     <= ST_RUN;
                end
                default: begin
                    r_state     <= ST_RUN;
                    r_exc_taken <= 1'b0;
                end
            endcase
        end
    end

    assign pc        = r_pc;
    assign epc       = r_epc;
    assign cause     = r_cause;
    assign exc_taken = r_exc_taken;

endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for pc_next_unit: directed vector table, hand-written reset/trap
// sequences, then randomized traffic checked against a behavioural model.
module tb_pc_next_unit;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned SEL_W   = 3;
    localparam logic [31:0] EXC_VEC = 32'h0000_00FC;

    logic                     clk;
    logic                     reset;
    logic                     pc_write;
    logic                     pc_write_cond;
    logic                     branch_ne;
    logic                     alu_zero;
    logic [SEL_W-1:0]         pc_src;
    logic [NUM_SRC*WIDTH-1:0] src_bus;
    logic                     exc_req;
    logic [4:0]               exc_code;
    logic [WIDTH-1:0]         pc;
    logic [WIDTH-1:0]         epc;
    logic [4:0]               cause;
    logic                     exc_taken;
    logic                     sel_err;

    pc_next_unit #(
        .WIDTH        (WIDTH),
        .NUM_SRC      (NUM_SRC),
        .SEL_W        (SEL_W),
        .RESET_VECTOR (32'h0000_0000),
        .EXC_VECTOR   (EXC_VEC),
        .PC_INC       (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_ne     (branch_ne),
        .alu_zero      (alu_zero),
        .pc_src        (pc_src),
        .src_bus       (src_bus),
        .exc_req       (exc_req),
        .exc_code      (exc_code),
        .pc            (pc),
        .epc           (epc),
        .cause         (cause),
        .exc_taken     (exc_taken),
        .sel_err       (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pc_write = 1'b0; pc_write_cond = 1'b0; branch_ne = 1'b0; alu_zero = 1'b0;
        pc_src = 3'd0; exc_req = 1'b0; exc_code = 5'd0;
    endtask

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_pc, m_epc;
    logic [4:0]  m_cause;
    logic        m_taken;
    bit          m_trap_next;   // next edge delivers the exception vector

    function automatic bit m_write();
        bit taken_branch;
        taken_branch = branch_ne ? !alu_zero : alu_zero;
        return pc_write || (pc_write_cond && taken_branch);
    endfunction

    function automatic bit m_sel_err();
        return m_write() && (int'(pc_src) > int'(NUM_SRC));
    endfunction

    task automatic model_edge();
        logic [31:0] tgt;
        if (m_trap_next) begin
            m_pc = EXC_VEC; m_taken = 1'b1; m_trap_next = 0;
        end else begin
            m_taken = 1'b0;
            if (exc_req) begin
                m_epc = m_pc - 32'd4; m_cause = exc_code; m_trap_next = 1;
            end else if (m_write() && int'(pc_src) <= int'(NUM_SRC)) begin
                tgt = (int'(pc_src) == int'(NUM_SRC)) ? m_epc : src_bus[int'(pc_src)*32 +: 32];
                if (tgt % 4 != 0) begin
                    m_epc = m_pc - 32'd4; m_cause = 5'd4; m_trap_next = 1;
                end else begin
                    m_pc = tgt;
                end
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        pw, pwc, bne, z;
        logic [2:0]  src;
        logic        er;
        logic [4:0]  code;
        logic [31:0] e_pc, e_epc;
        logic [4:0]  e_cause;
        logic        e_tk, e_se;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic pw, input logic pwc, input logic bne, input logic z,
                       input logic [2:0] src, input logic er, input logic [4:0] code,
                       input logic [31:0] e_pc, input logic [31:0] e_epc,
                       input logic [4:0] e_cause, input logic e_tk, input logic e_se);
        vec_t v;
        v.pw = pw; v.pwc = pwc; v.bne = bne; v.z = z; v.src = src; v.er = er; v.code = code;
        v.e_pc = e_pc; v.e_epc = e_epc; v.e_cause = e_cause; v.e_tk = e_tk; v.e_se = e_se;
        vecs.push_back(v);
    endtask

    initial begin
        //   pw pwc bne z  src er code   pc            epc           cause tk se
        add(1, 0, 0, 0, 3'd1, 0, 5'd0,  32'h40,       32'h0,        5'd0,  0, 0); // load slot1
        add(0, 0, 0, 0, 3'd1, 0, 5'd0,  32'h40,       32'h0,        5'd0,  0, 0); // hold
        add(0, 1, 0, 0, 3'd0, 0, 5'd0,  32'h40,       32'h0,        5'd0,  0, 0); // beq not taken
        add(0, 1, 0, 1, 3'd0, 0, 5'd0,  32'h80,       32'h0,        5'd0,  0, 0); // beq taken
        add(0, 1, 1, 0, 3'd1, 0, 5'd0,  32'h40,       32'h0,        5'd0,  0, 0); // bne taken
        add(0, 1, 1, 1, 3'd0, 0, 5'd0,  32'h40,       32'h0,        5'd0,  0, 0); // bne not taken
        add(1, 0, 0, 0, 3'd3, 0, 5'd0,  32'h104,      32'h0,        5'd0,  0, 0); // pc=0x104
        add(0, 0, 0, 0, 3'd0, 1, 5'd12, 32'h104,      32'h100,      5'd12, 0, 0); // exc entry
        add(1, 0, 0, 0, 3'd1, 1, 5'd10, 32'hFC,       32'h100,      5'd12, 1, 0); // TRAP ignores inputs
        add(0, 0, 0, 0, 3'd0, 0, 5'd0,  32'hFC,       32'h100,      5'd12, 0, 0); // pulse ends
        add(1, 0, 0, 0, 3'd2, 0, 5'd0,  32'hFC,       32'hF8,       5'd4,  0, 0); // misaligned -> AdEL
        add(0, 0, 0, 0, 3'd0, 0, 5'd0,  32'hFC,       32'hF8,       5'd4,  1, 0); // vector
        add(1, 0, 0, 0, 3'd4, 0, 5'd0,  32'hF8,       32'hF8,       5'd4,  0, 0); // ERET
        add(1, 0, 0, 0, 3'd7, 0, 5'd0,  32'hF8,       32'hF8,       5'd4,  0, 1); // sel_err holds
        add(1, 0, 0, 0, 3'd2, 1, 5'd10, 32'hF8,       32'hF4,       5'd10, 0, 0); // exc beats misaligned
        add(0, 0, 0, 0, 3'd0, 0, 5'd0,  32'hFC,       32'hF4,       5'd10, 1, 0); // vector
        add(0, 0, 0, 0, 3'd7, 0, 5'd0,  32'hFC,       32'hF4,       5'd10, 0, 0); // no write, no sel_err
        add(0, 1, 0, 1, 3'd7, 0, 5'd0,  32'hFC,       32'hF4,       5'd10, 0, 1); // branch, bad select
    end

    initial begin
        logic [31:0] s;
        idle();
        src_bus = {32'h0000_0104, 32'h0000_0042, 32'h0000_0040, 32'h0000_0080};
        reset = 1'b0;

        // Async reset applied away from any clock edge
        #3 reset = 1'b1;
        #1;
        chk("rst_pc",    pc, 32'h0);
        chk("rst_epc",   epc, 32'h0);
        chk("rst_cause", 32'(cause), 32'h0);
        chk("rst_taken", 32'(exc_taken), 32'h0);
        tick();
        reset = 1'b0;

        foreach (vecs[i]) begin
            pc_write = vecs[i].pw; pc_write_cond = vecs[i].pwc;
            branch_ne = vecs[i].bne; alu_zero = vecs[i].z;
            pc_src = vecs[i].src; exc_req = vecs[i].er; exc_code = vecs[i].code;
            #1;
            chk($sformatf("v%0d_sel_err", i), 32'(sel_err), 32'(vecs[i].e_se));
            tick();
            chk($sformatf("v%0d_pc", i),    pc, vecs[i].e_pc);
            chk($sformatf("v%0d_epc", i),   epc, vecs[i].e_epc);
            chk($sformatf("v%0d_cause", i), 32'(cause), 32'(vecs[i].e_cause));
            chk($sformatf("v%0d_taken", i), 32'(exc_taken), 32'(vecs[i].e_tk));
        end

        // Reset in the middle of a trap aborts it
        idle();
        exc_req = 1'b1; exc_code = 5'd10;
        tick();
        idle();
        #2 reset = 1'b1;
        #1;
        chk("midtrap_rst_pc",    pc, 32'h0);
        chk("midtrap_rst_epc",   epc, 32'h0);
        chk("midtrap_rst_cause", 32'(cause), 32'h0);
        #2 reset = 1'b0;
        tick();
        chk("midtrap_abort_pc",    pc, 32'h0);
        chk("midtrap_abort_taken", 32'(exc_taken), 32'h0);

        // Exception at pc=0: EPC wraps
        exc_req = 1'b1; exc_code = 5'd12;
        tick();
        idle();
        chk("wrap_epc",   epc, 32'hFFFF_FFFC);
        chk("wrap_cause", 32'(cause), 32'd12);
        chk("wrap_pc",    pc, 32'h0);
        tick();
        chk("wrap_vec_pc", pc, EXC_VEC);
        chk("wrap_taken",  32'(exc_taken), 32'h1);
        tick();
        chk("wrap_pulse_end", 32'(exc_taken), 32'h0);

        // Randomized traffic against the reference model
        m_pc = EXC_VEC; m_epc = 32'hFFFF_FFFC; m_cause = 5'd12; m_taken = 1'b0; m_trap_next = 0;
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < int'(NUM_SRC); k++) begin
                s = $urandom;
                if ($urandom_range(0, 3) != 0) s[1:0] = 2'b00;
                src_bus[k*32 +: 32] = s;
            end
            pc_write      = ($urandom_range(0, 2) == 0);
            pc_write_cond = ($urandom_range(0, 2) == 0);
            branch_ne     = 1'($urandom_range(0, 1));
            alu_zero      = 1'($urandom_range(0, 1));
            pc_src        = 3'($urandom_range(0, 7));
            exc_req       = ($urandom_range(0, 9) == 0);
            exc_code      = 5'($urandom_range(0, 31));
            #1;
            chk($sformatf("r%0d_sel_err", n), 32'(sel_err), 32'(m_sel_err()));
            model_edge();
            tick();
            chk($sformatf("r%0d_pc", n),    pc, m_pc);
            chk($sformatf("r%0d_epc", n),   epc, m_epc);
            chk($sformatf("r%0d_cause", n), 32'(cause), 32'(m_cause));
            chk($sformatf("r%0d_taken", n), 32'(exc_taken), 32'(m_taken));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
